// File: rtl/mdu_pkg.sv
// Shared MDU definitions: divider FSM states, default operand width,
// divider latency and the iteration counter width.
package mdu_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_FIX,
    DIV_DONE
  } div_state_e;

  localparam int MDU_XLEN = 64;
  localparam int DIV_LAT  = MDU_XLEN + 2;

  function automatic int div_cnt_w(input int xlen);
    return (xlen > 1) ? $clog2(xlen) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// subtract the divisor if it fits, and report the resulting quotient bit.
module div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem,
  input  logic            bit_in,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_next,
  output logic            q_bit
);

  // The shifted value keeps rem's MSB so divisors above 2^(XLEN-1) still work.
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;

  assign shifted  = {rem, bit_in};
  assign q_bit    = (shifted >= {1'b0, dvs});
  assign diff     = shifted[XLEN-1:0] - dvs;
  assign rem_next = q_bit ? diff : shifted[XLEN-1:0];

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider answering the MDU trig/okay handshake; returns
// {remainder, quotient} for DIV/DIVU/REM/REMU on pre-extended operands.
module div_iter
  import mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic              flush,
  input  logic              signed1,
  input  logic [XLEN-1:0]   src1,
  input  logic              signed2,
  input  logic [XLEN-1:0]   src2,
  output logic [2*XLEN-1:0] out,
  output logic              okay,
  output logic              busy
);

  localparam int CW = div_cnt_w(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] dvd;
  logic [XLEN-1:0] dvs;
  logic [XLEN-1:0] rem;
  logic            neg_q;
  logic            neg_r;

  logic            s1;
  logic            s2;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic            div_zero;
  logic            ovf;
  logic            start;
  logic [XLEN-1:0] rem_next;
  logic            q_bit;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;

  assign s1       = signed1 & src1[XLEN-1];
  assign s2       = signed2 & src2[XLEN-1];
  assign mag1     = s1 ? -src1 : src1;
  assign mag2     = s2 ? -src2 : src2;
  assign div_zero = (src2 == '0);
  assign ovf      = signed1 & signed2 & (src1 == MIN_INT) & (src2 == '1);
  assign start    = (state == DIV_IDLE) & trig & ~flush;

  // dvd doubles as the quotient: each step shifts a dividend bit out and a q bit in.
  assign q_fix = neg_q ? -dvd : dvd;
  assign r_fix = neg_r ? -rem : rem;

  assign okay = (state == DIV_DONE);
  assign busy = (state != DIV_IDLE);

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem),
    .bit_in   (dvd[XLEN-1]),
    .dvs      (dvs),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DIV_IDLE;
      cnt   <= '0;
      out   <= '0;
    end else if (flush) begin
      state <= DIV_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (trig) begin
            if (div_zero) begin
              out   <= {src1, {XLEN{1'b1}}};
              state <= DIV_DONE;
            end else if (ovf) begin
              out   <= {{XLEN{1'b0}}, src1};
              state <= DIV_DONE;
            end else begin
              cnt   <= '0;
              state <= DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(XLEN - 1)) begin
            state <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          out   <= {r_fix, q_fix};
          state <= DIV_DONE;
        end
        default: begin
          state <= DIV_IDLE;
        end
      endcase
    end
  end

  // Datapath registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    if (start) begin
      dvd   <= mag1;
      dvs   <= mag2;
      rem   <= '0;
      neg_q <= s1 ^ s2;
      neg_r <= s1;
    end else if (state == DIV_CALC) begin
      rem <= rem_next;
      dvd <= {dvd[XLEN-2:0], q_bit};
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Randomised self-checking bench for div_iter (XLEN=64) against an
// integer-arithmetic reference with per-cycle okay/busy/out checking.
module tb_div_iter;
  import mdu_pkg::*;

  localparam int XLEN = 64;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         trig = 1'b0;
  logic         flush = 1'b0;
  logic         signed1 = 1'b0;
  logic         signed2 = 1'b0;
  logic [63:0]  src1 = '0;
  logic [63:0]  src2 = '0;
  logic [127:0] out;
  logic         okay;
  logic         busy;

  div_iter #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .rst     (rst),
    .trig    (trig),
    .flush   (flush),
    .signed1 (signed1),
    .src1    (src1),
    .signed2 (signed2),
    .src2    (src2),
    .out     (out),
    .okay    (okay),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int tcyc = 0;
  always @(posedge clk) tcyc <= tcyc + 1;

  int checks = 0;
  int errors = 0;

  bit           m_active = 1'b0;
  int           m_start = 0;
  int           m_done = 0;
  int           m_kill = 1 << 30;
  logic [127:0] m_res = '0;
  logic [127:0] exp_out = '0;
  int           last_okay = -1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, tcyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact integer division of the operands as mathematical values.
  function automatic logic [127:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                           input logic s1, input logic s2);
    logic signed [129:0] x, y, q, r;
    if (b == '0) return {a, ONES};
    x = s1 ? {{66{a[63]}}, a} : {66'b0, a};
    y = s2 ? {{66{b[63]}}, b} : {66'b0, b};
    q = x / y;
    r = x % y;
    return {r[63:0], q[63:0]};
  endfunction

  function automatic bit is_special(input logic [63:0] a, input logic [63:0] b,
                                    input logic s1, input logic s2);
    return (b == '0) || (s1 && s2 && a == MINV && b == ONES);
  endfunction

  always @(negedge clk) begin
    if (m_active && tcyc > m_kill) m_active = 1'b0;
    if (m_active && tcyc == m_done) exp_out = m_res;
    chk1("okay", okay, m_active && tcyc == m_done);
    chk1("busy", busy, m_active && tcyc > m_start && tcyc <= m_done);
    chk("out", out, exp_out);
    if (okay === 1'b1) last_okay = tcyc;
    if (m_active && tcyc >= m_done) m_active = 1'b0;
  end

  task automatic wait_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic start_op(input logic [63:0] a, input logic [63:0] b,
                          input logic s1, input logic s2);
    src1    = a;
    src2    = b;
    signed1 = s1;
    signed2 = s2;
    trig    = 1'b1;
    m_start = tcyc;
    m_res   = ref_div(a, b, s1, s2);
    m_done  = tcyc + (is_special(a, b, s1, s2) ? 1 : DIV_LAT);
    m_kill  = 1 << 30;
    m_active = 1'b1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (m_active && n < 200) begin
      wait_neg();
      n++;
    end
    if (m_active) begin
      checks++;
      errors++;
      $display("FAIL timeout: okay not seen within %0d cycles", n);
      m_active = 1'b0;
    end
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        input logic s1, input logic s2, input int hold);
    wait_neg();
    start_op(a, b, s1, s2);
    repeat (hold) wait_neg();
    trig = 1'b0;
    wait_done();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, b;
    logic s1, s2;
    int pat;

    chk("model_100_7", ref_div(64'd100, 64'd7, 1'b0, 1'b0), {64'd2, 64'd14});
    chk("model_m7_2", ref_div(-64'sd7, 64'd2, 1'b1, 1'b1), {ONES, 64'hFFFF_FFFF_FFFF_FFFD});
    chk("model_ovf", ref_div(MINV, ONES, 1'b1, 1'b1), {64'd0, MINV});

    repeat (3) @(negedge clk);
    #1;
    chk("reset_out", out, '0);
    chk1("reset_okay", okay, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    rst = 1'b0;

    run_op(64'd100, 64'd7, 1'b0, 1'b0, 1);
    chk("divu_100_7", out, {64'd2, 64'd14});
    chk_int("lat_100_7", last_okay - m_start, 66);

    run_op(-64'sd7, 64'd2, 1'b1, 1'b1, 1);
    chk("div_m7_2", out, {ONES, 64'hFFFF_FFFF_FFFF_FFFD});

    run_op(ONES, 64'd2, 1'b0, 1'b0, 1);
    chk("divu_max_2", out, {64'd1, 64'h7FFF_FFFF_FFFF_FFFF});

    run_op(64'd5, 64'd0, 1'b1, 1'b1, 1);
    chk("div_5_0", out, {64'd5, ONES});
    chk_int("lat_div0", last_okay - m_start, 1);

    run_op(64'd5, 64'd0, 1'b0, 1'b0, 1);
    chk("divu_5_0", out, {64'd5, ONES});

    run_op(MINV, ONES, 1'b1, 1'b1, 1);
    chk("div_ovf", out, {64'd0, MINV});
    chk_int("lat_ovf", last_okay - m_start, 1);

    // Abort in cycle 10 of a long op; the previous result must survive.
    wait_neg();
    start_op(64'd100, 64'd7, 1'b0, 1'b0);
    wait_neg();
    trig = 1'b0;
    repeat (9) wait_neg();
    flush  = 1'b1;
    m_kill = m_start + 10;
    wait_neg();
    flush = 1'b0;
    chk1("flush_busy", busy, 1'b0);
    chk("flush_out", out, {64'd0, MINV});
    wait_done();
    run_op(64'd9, 64'd3, 1'b0, 1'b0, 1);
    chk("divu_9_3", out, {64'd0, 64'd3});

    run_op(64'd1000, 64'd10, 1'b0, 1'b0, 40);
    chk("trig_held", out, {64'd0, 64'd100});
    chk_int("lat_trig_held", last_okay - m_start, 66);

    // Asynchronous reset in the middle of CALC.
    wait_neg();
    start_op(64'd100, 64'd7, 1'b0, 1'b0);
    wait_neg();
    trig = 1'b0;
    repeat (19) wait_neg();
    #2;
    m_active = 1'b0;
    exp_out  = '0;
    rst = 1'b1;
    #1;
    chk("rst_mid_out", out, '0);
    chk1("rst_mid_busy", busy, 1'b0);
    chk1("rst_mid_okay", okay, 1'b0);
    wait_neg();
    wait_neg();
    rst = 1'b0;

    run_op(64'd77, 64'd5, 1'b0, 1'b0, 1);
    chk("b2b_first", out, {64'd2, 64'd15});
    run_op(-64'sd77, 64'd5, 1'b1, 1'b1, 1);
    chk("b2b_second", out, {64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF1});

    for (int i = 0; i < 40; i++) begin
      pat = $urandom_range(0, 5);
      s1 = 1'($urandom_range(0, 1));
      s2 = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case (pat)
        1: begin
          a = 64'($urandom_range(0, 1000));
          b = 64'($urandom_range(1, 40));
          if (s1 && $urandom_range(0, 1) == 1) a = -a;
          if (s2 && $urandom_range(0, 1) == 1) b = -b;
        end
        2: b = '0;
        3: begin
          a = MINV; b = ONES; s1 = 1'b1; s2 = 1'b1;
        end
        4: b[63] = 1'b1;
        5: b = 64'($urandom_range(1, 16));
        default: ;
      endcase
      run_op(a, b, s1, s2, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
